// File: rtl/prbs_15_checker.sv
// -----------------------------------------------------------------------------
// prbs_15_checker
//
// Receive-side checker for the PRBS-15 byte generator. It hunts for the first
// preamble byte, checks n repetitions of the 32-bit preamble pattern, then
// strips the PRBS-15 scrambling from each following byte with a local LFSR.
// The descrambled byte is compared against the same 32-bit pattern.
//
// Ports
//   clk          in   1   system clock, rising-edge
//   rst          in   1   asynchronous reset, active low
//   enable       in   1   byte-valid strobe
//   Byte_in      in   8   received byte
//   bytes_in     in  32   expected pattern, byte 0 in [7:0]; used live
//   n            in   8   pattern repetitions, latched when leaving HUNT
//   locked       out  1   high in PATTERN or PRBS
//   pattern_done out  1   sticky, set after the 4n-th pattern byte
//   pattern_err  out  1   sticky, set on any pattern-phase mismatch
//   err_pulse    out  1   one-cycle pulse per mismatching byte
//   byte_err_cnt out 16   PRBS-phase mismatching bytes, saturating
//   bit_err_cnt  out 24   PRBS-phase mismatching bits, saturating
// -----------------------------------------------------------------------------
module prbs_15_checker #(
    parameter logic [14:0] SEED = 15'h7FFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  Byte_in,
    input  logic [31:0] bytes_in,
    input  logic [7:0]  n,
    output logic        locked,
    output logic        pattern_done,
    output logic        pattern_err,
    output logic        err_pulse,
    output logic [15:0] byte_err_cnt,
    output logic [23:0] bit_err_cnt
);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PATTERN = 2'd1;
    localparam logic [1:0] ST_PRBS    = 2'd2;

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    logic [1:0]  state_q,   state_d;
    logic [1:0]  idx_q,     idx_d;
    logic [7:0]  n_q,       n_d;
    logic [9:0]  rep_cnt_q, rep_cnt_d;   // pattern bytes checked so far
    logic [14:0] lfsr_q,    lfsr_d;
    logic        locked_q,  locked_d;
    logic        done_q,    done_d;
    logic        perr_q,    perr_d;
    logic        pulse_q,   pulse_d;
    logic [15:0] bcnt_q,    bcnt_d;
    logic [23:0] bitcnt_q,  bitcnt_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [7:0]  expected_byte;
    logic [7:0]  prbs_byte;
    logic [14:0] lfsr_adv;
    logic [7:0]  descrambled;
    logic [7:0]  bit_diff;
    logic [3:0]  bit_diff_cnt;
    logic [24:0] bit_sum;
    logic [9:0]  pattern_len;
    logic        last_pattern_byte;
    logic        prbs_check;

    assign expected_byte = bytes_in[{idx_q, 3'b000} +: 8];

    // Eight LFSR steps per byte; the first bit produced lands in bit 0.
    always_comb begin
        logic [14:0] s;
        logic        fb;
        s         = lfsr_q;
        prbs_byte = 8'h00;
        for (int i = 0; i < 8; i++) begin
            fb           = s[14] ^ s[13];
            prbs_byte[i] = fb;
            s            = {s[13:0], fb};
        end
        lfsr_adv = s;
    end

    assign descrambled = Byte_in ^ prbs_byte;
    assign bit_diff    = descrambled ^ expected_byte;

    always_comb begin
        bit_diff_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            bit_diff_cnt = bit_diff_cnt + {3'b000, bit_diff[i]};
        end
    end

    // One bit wider than the counter so an overflow is visible for saturation.
    assign bit_sum = {1'b0, bitcnt_q} + {21'd0, bit_diff_cnt};

    // The hunt byte counts as the first pattern byte, so the phase ends when
    // the byte about to be accepted is number 4n.
    assign pattern_len       = {n_q, 2'b00};
    assign last_pattern_byte = ((rep_cnt_q + 10'd1) == pattern_len);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every _d signal takes its held value first, so no path through
    // this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        rep_cnt_d  = rep_cnt_q;
        lfsr_d     = lfsr_q;
        locked_d   = locked_q;
        done_d     = done_q;
        perr_d     = perr_q;
        pulse_d    = 1'b0;
        bcnt_d     = bcnt_q;
        bitcnt_d   = bitcnt_q;
        prbs_check = 1'b0;

        if (enable) begin
            case (state_q)
                ST_HUNT: begin
                    if (n != 8'd0) begin
                        // Non-matching bytes are simply skipped while hunting.
                        if (Byte_in == bytes_in[7:0]) begin
                            n_d       = n;
                            rep_cnt_d = 10'd1;
                            idx_d     = 2'd1;
                            state_d   = ST_PATTERN;
                            locked_d  = 1'b1;
                        end
                    end else begin
                        // No preamble: this byte is already the first PRBS
                        // byte. LFSR and idx still hold their reset values.
                        state_d    = ST_PRBS;
                        locked_d   = 1'b1;
                        prbs_check = 1'b1;
                    end
                end

                ST_PATTERN: begin
                    idx_d = idx_q + 2'd1;
                    if (Byte_in != expected_byte) begin
                        perr_d  = 1'b1;
                        pulse_d = 1'b1;
                    end
                    if (last_pattern_byte) begin
                        done_d  = 1'b1;
                        lfsr_d  = SEED;
                        idx_d   = 2'd0;
                        state_d = ST_PRBS;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 10'd1;
                    end
                end

                ST_PRBS: begin
                    prbs_check = 1'b1;
                end

                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        // The LFSR and index advance on every accepted PRBS byte, good or bad,
        // so a corrupted byte never desynchronises the descrambler.
        if (prbs_check) begin
            lfsr_d = lfsr_adv;
            idx_d  = idx_q + 2'd1;
            if (bit_diff != 8'h00) begin
                pulse_d = 1'b1;
                if (bcnt_q != 16'hFFFF) begin
                    bcnt_d = bcnt_q + 16'd1;
                end
                bitcnt_d = bit_sum[24] ? 24'hFF_FFFF : bit_sum[23:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_HUNT;
            idx_q     <= 2'd0;
            n_q       <= 8'd0;
            rep_cnt_q <= 10'd0;
            lfsr_q    <= SEED;
            locked_q  <= 1'b0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            pulse_q   <= 1'b0;
            bcnt_q    <= 16'd0;
            bitcnt_q  <= 24'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            rep_cnt_q <= rep_cnt_d;
            lfsr_q    <= lfsr_d;
            locked_q  <= locked_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            pulse_q   <= pulse_d;
            bcnt_q    <= bcnt_d;
            bitcnt_q  <= bitcnt_d;
        end
    end

    assign locked       = locked_q;
    assign pattern_done = done_q;
    assign pattern_err  = perr_q;
    assign err_pulse    = pulse_q;
    assign byte_err_cnt = bcnt_q;
    assign bit_err_cnt  = bitcnt_q;

endmodule

// File: tb/tb_prbs_15_checker.sv
module tb_prbs_15_checker;

    localparam logic [14:0] SEED   = 15'h7FFF;
    localparam int          NBYTES = 70000;
    localparam logic [31:0] PAT_A  = 32'h3ACF491E;
    localparam logic [31:0] PAT_B  = 32'h4DF1A98B;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        enable   = 1'b0;
    logic [7:0]  Byte_in  = 8'h00;
    logic [31:0] bytes_in = 32'h0;
    logic [7:0]  n        = 8'h00;
    logic        locked, pattern_done, pattern_err, err_pulse;
    logic [15:0] byte_err_cnt;
    logic [23:0] bit_err_cnt;

    always #5 clk = ~clk;

    prbs_15_checker #(.SEED(SEED)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .Byte_in      (Byte_in),
        .bytes_in     (bytes_in),
        .n            (n),
        .locked       (locked),
        .pattern_done (pattern_done),
        .pattern_err  (pattern_err),
        .err_pulse    (err_pulse),
        .byte_err_cnt (byte_err_cnt),
        .bit_err_cnt  (bit_err_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // PRBS bit sequence as a plain recurrence: the first 15 entries are the
    // seed read from bit 14 down, then x[i] = x[i-15] ^ x[i-14]. Output bit j
    // of the descrambler is x[15+j].
    bit xs [0:8*NBYTES+14];

    function automatic logic [7:0] prbs_at(input int k);
        logic [7:0] p;
        for (int b = 0; b < 8; b++) p[b] = xs[15 + 8*k + b];
        return p;
    endfunction

    function automatic logic [7:0] pat_byte(input logic [31:0] pat, input int i);
        return pat[8*(i%4) +: 8];
    endfunction

    function automatic logic [7:0] golden(input logic [31:0] pat, input int k);
        return pat_byte(pat, k) ^ prbs_at(k);
    endfunction

    // ---------------- reference model ----------------
    typedef enum {M_HUNT, M_PAT, M_PRBS} mphase_t;
    mphase_t m_phase;
    int      m_n, m_pat_cnt, m_k, m_bcnt, m_bitcnt;
    bit      m_locked, m_done, m_perr, m_pulse;

    task automatic model_reset();
        m_phase = M_HUNT; m_n = 0; m_pat_cnt = 0; m_k = 0;
        m_bcnt = 0; m_bitcnt = 0;
        m_locked = 0; m_done = 0; m_perr = 0; m_pulse = 0;
    endtask

    task automatic model_prbs(input logic [7:0] b, input logic [31:0] pat);
        logic [7:0] diff;
        diff = (b ^ prbs_at(m_k)) ^ pat_byte(pat, m_k);
        if (diff != 8'h00) begin
            m_pulse  = 1;
            m_bcnt   = (m_bcnt + 1 > 65535) ? 65535 : m_bcnt + 1;
            m_bitcnt = (m_bitcnt + $countones(diff) > 24'hFFFFFF) ? 24'hFFFFFF
                                                                 : m_bitcnt + $countones(diff);
        end
        m_k++;
    endtask

    task automatic model_step(input bit en, input logic [7:0] b,
                              input logic [31:0] pat, input logic [7:0] nn);
        m_pulse = 0;
        if (!en) return;
        case (m_phase)
            M_HUNT: begin
                if (nn != 0) begin
                    if (b == pat[7:0]) begin
                        m_phase = M_PAT; m_n = nn; m_pat_cnt = 1; m_locked = 1;
                    end
                end else begin
                    m_phase = M_PRBS; m_locked = 1;
                    model_prbs(b, pat);
                end
            end
            M_PAT: begin
                if (b != pat_byte(pat, m_pat_cnt)) begin m_perr = 1; m_pulse = 1; end
                m_pat_cnt++;
                if (m_pat_cnt == 4*m_n) begin
                    m_done = 1; m_phase = M_PRBS; m_k = 0;
                end
            end
            default: model_prbs(b, pat);
        endcase
    endtask

    function automatic logic [51:0] model_vec();
        logic [15:0] bc;
        logic [23:0] bt;
        bc = m_bcnt[15:0];
        bt = m_bitcnt[23:0];
        return {m_locked, m_done, m_perr, m_pulse, bc, bt};
    endfunction

    // ---------------- drivers ----------------
    task automatic send(input bit en, input logic [7:0] b,
                        input logic [31:0] pat, input logic [7:0] nn);
        @(negedge clk);
        enable = en; Byte_in = b; bytes_in = pat; n = nn;
        @(posedge clk);
        model_step(en, b, pat, nn);
        #1;
        check("outs", {locked, pattern_done, pattern_err, err_pulse, byte_err_cnt, bit_err_cnt},
              model_vec());
    endtask

    // Reset asserted away from any clock edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3 rst = 1'b0; enable = 1'b0;
        #1 model_reset();
        check({tag, "_locked"}, locked, 1'b0);
        check({tag, "_done"},   pattern_done, 1'b0);
        check({tag, "_perr"},   pattern_err, 1'b0);
        check({tag, "_pulse"},  err_pulse, 1'b0);
        check({tag, "_bcnt"},   byte_err_cnt, 16'h0);
        check({tag, "_bitcnt"}, bit_err_cnt, 24'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int k;
        int nn;
        logic [31:0] pat;

        for (int i = 0; i < 15; i++) xs[i] = SEED[14-i];
        for (int i = 15; i < 8*NBYTES+15; i++) xs[i] = xs[i-15] ^ xs[i-14];
        model_reset();

        // ---- run A: clean preamble, clean PRBS, one injected error ----
        do_reset("rst0");
        send(1, 8'h55, PAT_A, 8'd2);
        send(1, 8'hAA, PAT_A, 8'd2);
        check("hunt_idle_unlocked", locked, 1'b0);
        for (int i = 0; i < 8; i++) begin
            // n may wander after HUNT exit; the latched value must win.
            send(1, pat_byte(PAT_A, i), PAT_A, (i == 0) ? 8'd2 : 8'($urandom));
            if (i == 0) check("locked_first", locked, 1'b1);
            if (i == 6) check("done_not_early", pattern_done, 1'b0);
        end
        check("done_after_8", pattern_done, 1'b1);
        check("perr_clean", pattern_err, 1'b0);
        send(1, 8'h1E, PAT_A, 8'd2);
        send(1, 8'h09, PAT_A, 8'd2);
        check("p1_clean", byte_err_cnt, 16'd0);
        send(1, 8'hCF ^ prbs_at(2) ^ 8'h05, PAT_A, 8'd2);
        check("inj_pulse", err_pulse, 1'b1);
        check("inj_bcnt", byte_err_cnt, 16'd1);
        check("inj_bitcnt", bit_err_cnt, 24'd2);
        k = 3;
        for (int j = 0; j < 100; j++) begin
            if (j == 50) repeat (3) send(0, 8'($urandom), PAT_A, 8'd2);
            if ($urandom_range(0, 7) == 0) send(0, 8'($urandom), PAT_A, 8'd2);
            send(1, golden(PAT_A, k), PAT_A, 8'($urandom));
            k++;
        end
        check("clean_bcnt", byte_err_cnt, 16'd1);
        check("clean_bitcnt", bit_err_cnt, 24'd2);
        check("clean_pulse", err_pulse, 1'b0);

        // ---- run B: corrupted third preamble byte ----
        do_reset("rst_mid");
        for (int i = 0; i < 8; i++)
            send(1, (i == 2) ? 8'h00 : pat_byte(PAT_A, i), PAT_A, 8'd2);
        check("b_perr", pattern_err, 1'b1);
        check("b_done", pattern_done, 1'b1);
        check("b_bcnt", byte_err_cnt, 16'd0);
        for (int j = 0; j < 20; j++) send(1, golden(PAT_A, j), PAT_A, 8'd2);
        check("b_prbs_bcnt", byte_err_cnt, 16'd0);

        // ---- run D: n == 0 skips the preamble ----
        do_reset("rst_n0");
        send(1, 8'h1E, PAT_A, 8'd0);
        check("n0_locked", locked, 1'b1);
        check("n0_done", pattern_done, 1'b0);
        check("n0_pulse", err_pulse, 1'b0);
        send(1, 8'h09, PAT_A, 8'd0);
        send(1, 8'h00, PAT_A, 8'd0);
        check("n0_err_pulse", err_pulse, 1'b1);

        // ---- run C: randomized sessions ----
        for (int s = 0; s < 6; s++) begin
            do_reset("rst_rand");
            nn  = $urandom_range(0, 3);
            pat = $urandom;
            if (nn != 0) repeat ($urandom_range(0, 3)) send(1, 8'($urandom), pat, 8'(nn));
            for (int i = 0; i < 4*nn; i++)
                send(1, pat_byte(pat, i) ^ (($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00),
                     pat, 8'(nn));
            for (int j = 0; j < 40; j++) begin
                if ($urandom_range(0, 5) == 0) send(0, 8'($urandom), pat, 8'(nn));
                send(1, golden(pat, j) ^ (($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00),
                     pat, 8'(nn));
            end
            check("rand_bcnt", byte_err_cnt, 64'(m_bcnt));
            check("rand_bitcnt", bit_err_cnt, 64'(m_bitcnt));
        end

        // ---- run E: pattern switch, every byte bad, counter saturates ----
        do_reset("rst_sat");
        for (int i = 0; i < 4; i++) send(1, pat_byte(PAT_A, i), PAT_A, 8'd1);
        for (int j = 0; j < 65540; j++) begin
            send(1, golden(PAT_A, j), PAT_B, 8'd1);
            if (j == 2) check("switch_bcnt", byte_err_cnt, 16'd3);
        end
        check("sat_bcnt", byte_err_cnt, 16'hFFFF);
        check("sat_bitcnt", bit_err_cnt, 64'(m_bitcnt));
        check("sat_pulse", err_pulse, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_15_checker.md
# prbs_15_checker

Receive-side counterpart of the PRBS-15 byte generator. It consumes the generator's byte stream, verifies the n-times-repeated 32-bit preamble pattern, then descrambles the PRBS-15 phase with a local LFSR. It reports pattern status and saturating byte and bit error counts. It sits at the far end of the serial test link, on the same clock as the sampled byte stream.

## Interface
- SEED, 15'h7FFF, LFSR value loaded on entry to the PRBS phase; must equal the generator seed.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  byte-valid strobe; Byte_in is sampled only on edges where enable=1.
- Byte_in  in  8  received byte.
- bytes_in  in  32  expected pattern, byte 0 = [7:0] first; used live, never latched.
- n  in  8  number of pattern repetitions; latched on HUNT exit.
- locked  out  1  high while in PATTERN or PRBS state.
- pattern_done  out  1  sticky; set when the 4n-th pattern byte has been checked.
- pattern_err  out  1  sticky; set on any pattern-phase mismatch.
- err_pulse  out  1  one-cycle pulse for each mismatching byte, in either phase.
- byte_err_cnt  out  16  PRBS-phase mismatching bytes; saturates at 16'hFFFF.
- bit_err_cnt  out  24  PRBS-phase mismatching bits (popcount); saturates at 24'hFFFFFF.

## Operation
- States: HUNT, PATTERN, PRBS. Reset state is HUNT.
- The byte index idx (2 bits) selects the expected byte bytes_in[8*idx+:8]. It increments mod 4 on every accepted byte in PATTERN and PRBS.
- HUNT, n!=0:
  - On an enabled byte equal to bytes_in[7:0]: latch n, set rep_cnt=1 byte checked, idx=1, go to PATTERN.
  - If 4n==1 byte… (not possible; minimum is 4 bytes).
  - Non-matching bytes are ignored. No errors are counted in HUNT.
- HUNT, n==0: the first enabled byte goes straight to PRBS. That byte is the first PRBS byte and is checked.
- PATTERN: each enabled byte is compared with the expected byte.
  - Mismatch: pattern_err<=1 and err_pulse.
  - After 4n bytes in total (including the hunt byte): pattern_done<=1, load LFSR=SEED, idx=0, go to PRBS.
- PRBS:
  - LFSR s[14:0]. One step is fb=s[14]^s[13], s<={s[13:0],fb}, output bit fb.
  - Per enabled byte, 8 steps produce P, with the first-produced bit in P[0].
  - Descrambled byte D = Byte_in ^ P. Compare D with the expected byte.
  - Mismatch: byte_err_cnt+1 and bit_err_cnt+popcount(D^expected), both saturating, plus err_pulse.
  - The LFSR advances on every enabled byte regardless of errors.
  - PRBS is exited only by reset.
- enable=0: state, idx, LFSR and counters hold; err_pulse=0.
- Reset (any time, including mid-phase): asynchronously returns to HUNT.
  - All outputs go to 0.
  - LFSR=SEED, idx=0, latched n=0.

## Timing
- All outputs are registered. The status for the byte sampled at edge k is visible after edge k; err_pulse is high for exactly that cycle.
- One byte per cycle at full rate (enable held high). No back-pressure.
- Transition to PRBS occurs on the edge that accepts the last pattern byte. The next enabled byte uses P0.
- With SEED=7FFF, P0=8'h00 and P1=8'h40.
- Saturated counters hold their maximum. They clear only on reset.
- A bytes_in change takes effect on the next sampled byte.
- A change to n after HUNT exit has no effect.

## Test plan
- Reset, n=2, bytes_in=32'h3ACF491E; drive 1E,49,CF,3A,1E,49,CF,3A -> locked=1 after the first byte, pattern_done=1 after the 8th, pattern_err=0, no err_pulse.
- Continue with 1E^00=1E and 49^40=09, then the golden-model stream for 100 bytes -> byte_err_cnt=0, bit_err_cnt=0.
- In the PRBS phase, send byte 2 as CF^P2^8'h05 -> single err_pulse, byte_err_cnt=1, bit_err_cnt=2. Subsequent bytes remain clean, confirming the LFSR still advanced.
- Pattern phase with the 3rd byte corrupted to 8'h00 -> pattern_err=1, pattern_done still set after 8 bytes, byte_err_cnt=0.
- Idle bytes 55,AA before 1E in HUNT; toggle enable low for 3 cycles mid-PRBS -> no errors and no counter changes. Switch bytes_in to 32'h4DF1A98B while the generator stays on the old pattern -> every byte mismatches and byte_err_cnt increments per byte.
- Assert rst mid-PRBS with a nonzero count -> immediate HUNT, all outputs 0. Force byte_err_cnt to FFFE and inject 3 errors -> holds at FFFF.
